// File: rtl/dbus_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dbus_ctrl_pkg                                                   |
// | Brief    : Shared types and widths for the memory-stage data-bus controller.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package dbus_ctrl_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    UC_REQ  = 2'd1,
    UC_WAIT = 2'd2,
    UC_DONE = 2'd3
  } dbus_state_t;

  typedef struct packed {
    logic                  read;
    logic                  write;
    logic                  uncached;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wrdata;
    logic [BE_WIDTH-1:0]   be;
  } dbus_req_t;

endpackage
`default_nettype wire

// File: rtl/dbus_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dbus_ctrl_if                                                    |
// | Brief    : Request, dcache and uncached bus signals of dbus_ctrl.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface dbus_ctrl_if #(
  parameter int ADDR_WIDTH = dbus_ctrl_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = dbus_ctrl_pkg::DATA_WIDTH
);
  localparam int c_BE_WIDTH = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_read;
  logic                  req_write;
  logic                  req_uncached;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wrdata;
  logic [c_BE_WIDTH-1:0] req_be;
  logic                  dbus_ready;
  logic [DATA_WIDTH-1:0] rddata;
  logic                  rddata_valid;

  logic                  dc_req;
  logic                  dc_we;
  logic [ADDR_WIDTH-1:0] dc_addr;
  logic [DATA_WIDTH-1:0] dc_wrdata;
  logic [c_BE_WIDTH-1:0] dc_be;
  logic                  dc_stall;
  logic [DATA_WIDTH-1:0] dc_rddata;

  logic                  uc_req;
  logic                  uc_we;
  logic [ADDR_WIDTH-1:0] uc_addr;
  logic [DATA_WIDTH-1:0] uc_wrdata;
  logic [c_BE_WIDTH-1:0] uc_be;
  logic                  uc_ack;
  logic                  uc_rvalid;
  logic [DATA_WIDTH-1:0] uc_rddata;

  modport master (
    input  req_valid, req_read, req_write, req_uncached, req_addr, req_wrdata, req_be,
    output dbus_ready, rddata, rddata_valid,
    output dc_req, dc_we, dc_addr, dc_wrdata, dc_be,
    input  dc_stall, dc_rddata,
    output uc_req, uc_we, uc_addr, uc_wrdata, uc_be,
    input  uc_ack, uc_rvalid, uc_rddata
  );

  modport slave (
    output req_valid, req_read, req_write, req_uncached, req_addr, req_wrdata, req_be,
    input  dbus_ready, rddata, rddata_valid,
    input  dc_req, dc_we, dc_addr, dc_wrdata, dc_be,
    output dc_stall, dc_rddata,
    input  uc_req, uc_we, uc_addr, uc_wrdata, uc_be,
    output uc_ack, uc_rvalid, uc_rddata
  );

endinterface
`default_nettype wire

// File: rtl/dbus_ctrl_uc_wbuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dbus_ctrl_uc_wbuf                                               |
// | Brief    : One-entry posted uncached write buffer; exists only when        |
// |            DBUS_CTRL_UC_WBUF_EN is defined.                                |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`ifdef DBUS_CTRL_UC_WBUF_EN
module dbus_ctrl_uc_wbuf
  import dbus_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  dbus_req_t push_req,
  input  logic      ack,
  output logic      valid,
  output dbus_req_t entry
);

  logic      r_valid;
  dbus_req_t r_entry;

  // push is only raised while empty, so it never collides with a drain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_entry <= '0;
    end else if (push) begin
      r_valid <= 1'b1;
      r_entry <= push_req;
    end else if (r_valid && ack) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign entry = r_entry;

endmodule
`endif
`default_nettype wire

// File: rtl/dbus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dbus_ctrl                                                       |
// | Brief    : Memory-stage data-bus controller: dcache / uncached steering.   |
// |            Optional DBUS_CTRL_UC_WBUF_EN adds a posted uncached write buf. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dbus_ctrl
  import dbus_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = dbus_ctrl_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = dbus_ctrl_pkg::DATA_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  dbus_ctrl_if.master bus
);

  localparam int c_BE_WIDTH = DATA_WIDTH / 8;

  dbus_state_t           r_state;
  dbus_req_t             r_req;
  logic [DATA_WIDTH-1:0] r_uc_rddata;
  logic                  r_dc_rd_pend;

  logic      w_active;
  logic      w_cached;
  logic      w_uncached;
  logic      w_dc_accept;
  logic      w_uc_start;
  logic      w_wb_push;
  logic      w_ready;
  logic      w_uc_rd_done;
  dbus_req_t w_req_in;
  dbus_req_t w_uc_src;

  assign w_active    = bus.req_valid & (bus.req_read | bus.req_write);
  assign w_cached    = w_active & ~bus.req_uncached;
  assign w_uncached  = w_active & bus.req_uncached;
  assign w_dc_accept = w_cached & ~bus.dc_stall;

  // read+write together is a write
  always_comb begin
    w_req_in          = '0;
    w_req_in.read     = bus.req_read & ~bus.req_write;
    w_req_in.write    = bus.req_write;
    w_req_in.uncached = bus.req_uncached;
    w_req_in.addr     = bus.req_addr;
    w_req_in.wrdata   = bus.req_wrdata;
    w_req_in.be       = bus.req_be;
  end

`ifdef DBUS_CTRL_UC_WBUF_EN
  logic      w_wb_valid;
  dbus_req_t w_wb_entry;

  assign w_wb_push  = (r_state == IDLE) & w_uncached & bus.req_write & ~w_wb_valid;
  // a full buffer holds back every uncached access to keep ordering
  assign w_uc_start = (r_state == IDLE) & w_uncached & ~bus.req_write & ~w_wb_valid;

  dbus_ctrl_uc_wbuf u_uc_wbuf (
    .clk      (clk),
    .rst      (rst),
    .push     (w_wb_push),
    .push_req (w_req_in),
    .ack      (bus.uc_ack),
    .valid    (w_wb_valid),
    .entry    (w_wb_entry)
  );
`else
  assign w_wb_push  = 1'b0;
  assign w_uc_start = (r_state == IDLE) & w_uncached;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_uc_rddata  <= '0;
      r_dc_rd_pend <= 1'b0;
    end else begin
      r_dc_rd_pend <= w_dc_accept & ~bus.req_write;
      case (r_state)
        IDLE: begin
          if (w_uc_start) begin
            r_req   <= w_req_in;
            r_state <= UC_REQ;
          end
        end
        UC_REQ: begin
          if (bus.uc_ack) begin
            if (r_req.write) begin
              r_state <= UC_DONE;
            end else if (bus.uc_rvalid) begin
              r_uc_rddata <= bus.uc_rddata;
              r_state     <= UC_DONE;
            end else begin
              r_state <= UC_WAIT;
            end
          end
        end
        UC_WAIT: begin
          if (bus.uc_rvalid) begin
            r_uc_rddata <= bus.uc_rddata;
            r_state     <= UC_DONE;
          end
        end
        UC_DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_ready = 1'b1;
    case (r_state)
      IDLE: begin
        if (w_cached)
          w_ready = ~bus.dc_stall;
        else if (w_uncached)
          w_ready = w_wb_push;
      end
      UC_REQ, UC_WAIT: w_ready = 1'b0;
      default:         w_ready = 1'b1;
    endcase
  end

  // a live source is always an uncached read or write; all-zero means idle
  always_comb begin
    w_uc_src = '0;
    if (r_state == UC_REQ)
      w_uc_src = r_req;
`ifdef DBUS_CTRL_UC_WBUF_EN
    if (w_wb_valid)
      w_uc_src = w_wb_entry;
`endif
  end

  assign w_uc_rd_done = (r_state == UC_DONE) & r_req.read;

  assign bus.dbus_ready   = w_ready;
  assign bus.rddata_valid = r_dc_rd_pend | w_uc_rd_done;
  assign bus.rddata       = r_dc_rd_pend ? bus.dc_rddata :
                            (w_uc_rd_done ? r_uc_rddata : '0);

  assign bus.dc_req    = w_cached;
  assign bus.dc_we     = w_cached & bus.req_write;
  assign bus.dc_addr   = bus.req_addr & {ADDR_WIDTH{w_cached}};
  assign bus.dc_wrdata = bus.req_wrdata & {DATA_WIDTH{w_cached}};
  assign bus.dc_be     = bus.req_be & {c_BE_WIDTH{w_cached}};

  assign bus.uc_req    = w_uc_src.uncached & (w_uc_src.read | w_uc_src.write);
  assign bus.uc_we     = w_uc_src.write;
  assign bus.uc_addr   = w_uc_src.addr;
  assign bus.uc_wrdata = w_uc_src.wrdata;
  assign bus.uc_be     = w_uc_src.be;

endmodule
`default_nettype wire
